// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the memory/IO bus controller: FSM encodings,
// IO window default, error fill pattern and ctrl datapath field positions.
package ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    IO_WAIT  = 2'd2,
    DONE     = 2'd3
  } bus_state_e;

  localparam logic [3:0]  IO_BASE_DEF = 4'hF;
  localparam logic [31:0] ERR_FILL    = 32'hDEAD_BEEF;

  // Bit positions of MemRead/MemWrite inside the ctrl Datapath_signals vector.
  localparam int unsigned DS_MEMREAD_POS  = 12;
  localparam int unsigned DS_MEMWRITE_POS = 13;

  function automatic logic is_io(input logic [3:0] region, input logic [3:0] base);
    return region == base;
  endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response plus RAM and IO device signals of the bus controller.
interface mio_bus_ctrl_if #(parameter int unsigned ADDR_W = 10);
  logic              mem_read;
  logic              mem_write;
  logic              cpu_mio;
  logic [31:0]       addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              mio_ready;
  logic              bus_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_dout;
  logic              io_rd;
  logic              io_we;
  logic [27:0]       io_addr;
  logic [31:0]       io_wdata;
  logic [31:0]       io_rdata;
  logic              io_ready;

  modport master (
    output mem_read, mem_write, cpu_mio, addr, cpu_wdata, ram_dout, io_rdata, io_ready,
    input  cpu_rdata, mio_ready, bus_err, ram_en, ram_we, ram_addr, ram_wdata,
           io_rd, io_we, io_addr, io_wdata
  );

  modport slave (
    input  mem_read, mem_write, cpu_mio, addr, cpu_wdata, ram_dout, io_rdata, io_ready,
    output cpu_rdata, mio_ready, bus_err, ram_en, ram_we, ram_addr, ram_wdata,
           io_rd, io_we, io_addr, io_wdata
  );
endinterface

// File: rtl/mio_bus_ctrl_wait_cnt.sv
// Loadable up-counter with terminal-count compare; clear restarts from zero.
module mio_wait_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes ctrl accesses to RAM or the IO window,
// inserts RAM wait states, times out silent peripherals, returns load data.
module mio_bus_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RAM_LAT    = 2,
  parameter int unsigned IO_TIMEOUT = 15,
  parameter logic [3:0]  IO_BASE    = IO_BASE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mio_bus_ctrl_if.slave  bus
);

  bus_state_e  state_q, state_d;
  logic [27:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_wr_q, is_wr_d;
  logic        err_q, err_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic        io_rd_q, io_rd_d;
  logic        io_we_q, io_we_d;
  logic        ram_clr, io_clr;
  logic        ram_tc, io_tc;
  logic        req;

  // cpu_mio only qualifies the access; acceptance depends on MemRead/MemWrite.
  logic unused_cpu_mio;
  assign unused_cpu_mio = bus.cpu_mio;

  assign req = bus.mem_read | bus.mem_write;

  mio_wait_cnt #(.W(3)) u_ram_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (ram_clr),
    .en_i     (state_q == RAM_WAIT),
    .tc_val_i (3'(RAM_LAT - 1)),
    .tc_o     (ram_tc)
  );

  mio_wait_cnt #(.W(8)) u_io_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (io_clr),
    .en_i     (state_q == IO_WAIT),
    .tc_val_i (8'(IO_TIMEOUT - 1)),
    .tc_o     (io_tc)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    is_wr_d  = is_wr_q;
    err_d    = err_q;
    ram_en_d = 1'b0;
    ram_we_d = 1'b0;
    io_rd_d  = io_rd_q;
    io_we_d  = io_we_q;
    ram_clr  = 1'b0;
    io_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_read && bus.mem_write) begin
          // Conflicting request: flag it and still complete so ctrl moves on.
          err_d   = 1'b1;
          state_d = DONE;
        end else if (req) begin
          addr_d  = bus.addr[27:0];
          wdata_d = bus.cpu_wdata;
          is_wr_d = bus.mem_write;
          if (is_io(bus.addr[31:28], IO_BASE)) begin
            io_rd_d = bus.mem_read;
            io_we_d = bus.mem_write;
            io_clr  = 1'b1;
            state_d = IO_WAIT;
          end else begin
            ram_en_d = 1'b1;
            ram_we_d = bus.mem_write;
            ram_clr  = 1'b1;
            state_d  = RAM_WAIT;
          end
        end
      end
      RAM_WAIT: begin
        if (ram_tc) begin
          if (!is_wr_q) rdata_d = bus.ram_dout;
          state_d = DONE;
        end
      end
      IO_WAIT: begin
        if (bus.io_ready) begin
          if (!is_wr_q) rdata_d = bus.io_rdata;
          io_rd_d = 1'b0;
          io_we_d = 1'b0;
          state_d = DONE;
        end else if (io_tc) begin
          // Error fill goes to loads only; stores never disturb cpu_rdata.
          if (!is_wr_q) rdata_d = ERR_FILL;
          io_rd_d = 1'b0;
          io_we_d = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      is_wr_q  <= 1'b0;
      err_q    <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      io_rd_q  <= 1'b0;
      io_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      is_wr_q  <= is_wr_d;
      err_q    <= err_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      io_rd_q  <= io_rd_d;
      io_we_q  <= io_we_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.mio_ready = (state_q == DONE);
  assign bus.bus_err   = err_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = addr_q[ADDR_W+1:2];
  assign bus.ram_wdata = wdata_q;
  assign bus.io_rd     = io_rd_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_addr   = addr_q;
  assign bus.io_wdata  = wdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: RAM read/write, IO read, IO timeout,
// conflicting request and mid-transaction reset.
module tb_mio_bus_ctrl;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mio_bus_ctrl_if #(.ADDR_W(10)) bus ();

  mio_bus_ctrl #(
    .ADDR_W(10), .RAM_LAT(2), .IO_TIMEOUT(15), .IO_BASE(4'hF)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in the first cycle after the accept edge; scrambles the request
  // inputs, then counts strobe cycles and the cycle (1-based) of mio_ready.
  task automatic finish_txn(input int ready_at, output int n_en, output int n_we,
                            output int n_rd, output int n_iowe, output int rdy_at,
                            output int n_rdy);
    n_en = 0; n_we = 0; n_rd = 0; n_iowe = 0; rdy_at = 0; n_rdy = 0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = 32'h5555_5554;
    bus.cpu_wdata = 32'h0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (ready_at == k) bus.io_ready = 1'b1;
      n_en   += int'(bus.ram_en);
      n_we   += int'(bus.ram_we);
      n_rd   += int'(bus.io_rd);
      n_iowe += int'(bus.io_we);
      if (bus.mio_ready) begin
        n_rdy++;
        if (rdy_at == 0) rdy_at = k;
        bus.io_ready = 1'b0;
      end
      if (rdy_at != 0 && k == rdy_at + 1) break;
    end
  endtask

  task automatic accept();
    @(posedge clk); #1;
  endtask

  int n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy;

  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.cpu_mio = 0; bus.addr = 0;
    bus.cpu_wdata = 0; bus.ram_dout = 0; bus.io_rdata = 0; bus.io_ready = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_strobes", {28'h0, bus.ram_en, bus.ram_we, bus.io_rd, bus.io_we}, 32'h0);
    chk("rst_ready_err", {30'h0, bus.mio_ready, bus.bus_err}, 32'h0);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: RAM read
    bus.ram_dout = 32'h1234_5678; bus.addr = 32'h0000_0010; bus.mem_read = 1; bus.cpu_mio = 1;
    accept();
    chk("t1_ram_en", bus.ram_en, 1);
    chk("t1_ram_we", bus.ram_we, 0);
    chk("t1_ram_addr", 32'(bus.ram_addr), 4);
    finish_txn(0, n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy);
    chk("t1_en_cycles", n_en, 1);
    chk("t1_ready_cycle", rdy_at, 3);
    chk("t1_ready_pulses", n_rdy, 1);
    chk("t1_rdata", bus.cpu_rdata, 32'h1234_5678);

    // 2: RAM write
    bus.ram_dout = 32'h0BAD_0BAD; bus.addr = 32'h0000_0008; bus.cpu_wdata = 32'hA5A5_A5A5;
    bus.mem_write = 1;
    accept();
    chk("t2_ram_we", bus.ram_we, 1);
    chk("t2_ram_addr", 32'(bus.ram_addr), 2);
    chk("t2_ram_wdata", bus.ram_wdata, 32'hA5A5_A5A5);
    finish_txn(0, n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy);
    chk("t2_we_cycles", n_we, 1);
    chk("t2_en_cycles", n_en, 1);
    chk("t2_ready_cycle", rdy_at, 3);
    chk("t2_rdata_kept", bus.cpu_rdata, 32'h1234_5678);

    // 3: IO read, peripheral answers in the 4th strobe cycle
    bus.addr = 32'hF000_0004; bus.io_rdata = 32'h0000_00FF; bus.mem_read = 1;
    accept();
    chk("t3_io_rd", bus.io_rd, 1);
    chk("t3_io_addr", 32'(bus.io_addr), 32'h4);
    chk("t3_no_ram_en", bus.ram_en, 0);
    finish_txn(4, n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy);
    chk("t3_rd_cycles", n_rd, 4);
    chk("t3_ready_cycle", rdy_at, 5);
    chk("t3_ready_pulses", n_rdy, 1);
    chk("t3_rdata", bus.cpu_rdata, 32'h0000_00FF);
    chk("t3_bus_err", bus.bus_err, 0);

    // 4: IO write to a silent peripheral, then a RAM read with error still set
    bus.addr = 32'hF000_0100; bus.cpu_wdata = 32'h1357_9BDF; bus.mem_write = 1;
    accept();
    chk("t4_io_we", bus.io_we, 1);
    chk("t4_io_wdata", bus.io_wdata, 32'h1357_9BDF);
    finish_txn(0, n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy);
    chk("t4_we_cycles", n_iowe, 15);
    chk("t4_ready_cycle", rdy_at, 16);
    chk("t4_ready_pulses", n_rdy, 1);
    chk("t4_bus_err", bus.bus_err, 1);
    bus.addr = 32'h0000_0020; bus.ram_dout = 32'hCAFE_F00D; bus.mem_read = 1;
    accept();
    chk("t4b_ram_addr", 32'(bus.ram_addr), 8);
    finish_txn(0, n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy);
    chk("t4b_ready_cycle", rdy_at, 3);
    chk("t4b_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
    chk("t4b_bus_err_sticky", bus.bus_err, 1);

    // 6: reset in RAM_WAIT, then a fresh read
    bus.addr = 32'h0000_0040; bus.ram_dout = 32'h7777_0000; bus.mem_read = 1;
    accept();
    chk("t6_ram_en", bus.ram_en, 1);
    bus.mem_read = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_strobes", {28'h0, bus.ram_en, bus.ram_we, bus.io_rd, bus.io_we}, 32'h0);
    chk("t6_async_ready", bus.mio_ready, 0);
    chk("t6_async_state", 32'(dut.state_q), 32'(IDLE));
    chk("t6_bus_err_clr", bus.bus_err, 0);
    @(posedge clk); #1;
    chk("t6_no_ready", bus.mio_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.addr = 32'h0000_003C; bus.ram_dout = 32'h0F0F_1234; bus.mem_read = 1;
    accept();
    chk("t6b_ram_addr", 32'(bus.ram_addr), 15);
    finish_txn(0, n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy);
    chk("t6b_ready_cycle", rdy_at, 3);
    chk("t6b_rdata", bus.cpu_rdata, 32'h0F0F_1234);

    // 5: MemRead and MemWrite together
    bus.addr = 32'h0000_0080; bus.mem_read = 1; bus.mem_write = 1;
    accept();
    chk("t5_ready_next", bus.mio_ready, 1);
    chk("t5_bus_err", bus.bus_err, 1);
    finish_txn(0, n_en, n_we, n_rd, n_iowe, rdy_at, n_rdy);
    chk("t5_no_access", n_en + n_we + n_rd + n_iowe, 0);
    chk("t5_ready_cycle", rdy_at, 1);
    chk("t5_ready_pulses", n_rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
